// File: rtl/text_pkg.sv
// Shared grid constants, control codes and state encoding for the 64x24 text console.
// The VGA scan-out uses the same grid constants.
package text_pkg;

  localparam int TEXT_COLS   = 64;
  localparam int TEXT_ROWS   = 24;
  localparam int TEXT_CELLS  = 1536;
  localparam int TEXT_ADDR_W = 11;

  typedef logic [TEXT_ADDR_W-1:0] addr_t;

  localparam logic [7:0] CHAR_NL    = 8'h0A;
  localparam logic [7:0] CHAR_FF    = 8'h0C;
  localparam logic [7:0] CLEAR_CODE = 8'h00;

  localparam logic [5:0] LAST_COL = 6'(TEXT_COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(TEXT_ROWS - 1);

  localparam addr_t CELLS_A       = addr_t'(TEXT_CELLS);
  localparam addr_t COLS_A        = addr_t'(TEXT_COLS);
  // Copy runs one extra cycle so the final read can be written back.
  localparam addr_t SCROLL_LEN    = addr_t'(TEXT_CELLS - TEXT_COLS + 1);
  localparam addr_t LAST_ROW_BASE = addr_t'(TEXT_CELLS - TEXT_COLS);

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    PUT,
    CLR_ROW,
    SCROLL
  } state_t;

  // Row-major cell address: row * 64 is a plain 6-bit shift.
  function automatic addr_t cell_addr(input logic [5:0] x, input logic [4:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/text_fill_engine.sv
// Cell sequencer for bulk operations: fills a range with CLEAR_CODE, or copies
// the buffer up by one row (read address leads the write by one cycle).
// Optional feature macro: TEXT_SCROLL_EN (enables the read-address generator).
module text_fill_engine
  import text_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  addr_t      base,
  input  addr_t      count,
  input  logic       copy,
  input  logic [7:0] rdata,
  output logic       done,
  output logic       we,
  output addr_t      waddr,
  output logic [7:0] wdata,
  output addr_t      raddr
);

  logic  active;
  logic  copy_q;
  addr_t cnt;
  addr_t base_q;
  addr_t count_q;

  // In copy mode cycle 0 only issues a read; cycle k writes cell k-1.
  assign done  = active && (cnt == count_q - addr_t'(1));
  assign we    = active && (!copy_q || (cnt != '0));
  assign waddr = copy_q ? (base_q + cnt - addr_t'(1)) : (base_q + cnt);
  assign wdata = copy_q ? rdata : CLEAR_CODE;

  // Operation control; reset starts a full-screen clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active  <= 1'b1;
      cnt     <= '0;
      base_q  <= '0;
      count_q <= CELLS_A;
      copy_q  <= 1'b0;
    end else if (start) begin
      active  <= 1'b1;
      cnt     <= '0;
      base_q  <= base;
      count_q <= count;
      copy_q  <= copy;
    end else if (active) begin
      if (done) begin
        active <= 1'b0;
      end
      cnt <= cnt + addr_t'(1);
    end
  end

`ifdef TEXT_SCROLL_EN
  addr_t rd_next;
  assign rd_next = cnt + addr_t'(1);

  // Read address is registered one row ahead of the destination and leads by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      raddr <= '0;
    end else if (start) begin
      raddr <= copy ? (base + COLS_A) : '0;
    end else if (active && copy_q && (rd_next < count_q - addr_t'(1))) begin
      raddr <= base_q + COLS_A + rd_next;
    end else begin
      raddr <= '0;
    end
  end
`else
  assign raddr = '0;
`endif

endmodule

// File: rtl/text_console_writer.sv
// Character-stream writer for the 64x24 text buffer: prints at the cursor,
// handles newline / clear-screen, and scrolls or wraps on row overflow.
// Optional feature macro: TEXT_SCROLL_EN (scroll on overflow instead of wrap to row 0).
module text_console_writer
  import text_pkg::*;
(
  input  logic                   CLOCK_50,
  input  logic                   RESET_N,
  input  logic                   char_valid,
  input  logic [7:0]             char_data,
  output logic                   char_ready,
  output logic [TEXT_ADDR_W-1:0] mem_waddr,
  output logic [7:0]             mem_wdata,
  output logic                   mem_we,
  output logic [TEXT_ADDR_W-1:0] mem_raddr,
  input  logic [7:0]             mem_rdata,
  output logic [5:0]             cursor_x,
  output logic [4:0]             cursor_y,
  output logic                   busy
);

  state_t     state;
  state_t     next_state;
  logic [7:0] code;
  logic [5:0] x_nxt;
  logic [4:0] y_nxt;
  logic       adv;
  logic       put_we;

  logic       start;
  addr_t      start_base;
  addr_t      start_count;
  logic       start_copy;
  logic       fill_done;
  logic       fill_we;
  addr_t      fill_waddr;
  logic [7:0] fill_wdata;

  assign put_we = (state == PUT) && (code != CHAR_NL) && (code != CHAR_FF);

  text_fill_engine u_fill (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .start (start),
    .base  (start_base),
    .count (start_count),
    .copy  (start_copy),
    .rdata (mem_rdata),
    .done  (fill_done),
    .we    (fill_we),
    .waddr (fill_waddr),
    .wdata (fill_wdata),
    .raddr (mem_raddr)
  );

  // Next state, next cursor and bulk-operation launch.
  always_comb begin
    next_state  = state;
    x_nxt       = cursor_x;
    y_nxt       = cursor_y;
    adv         = 1'b0;
    start       = 1'b0;
    start_base  = '0;
    start_count = '0;
    start_copy  = 1'b0;
    case (state)
      CLEAR: begin
        if (fill_done) next_state = IDLE;
      end
      IDLE: begin
        if (char_valid) next_state = PUT;
      end
      PUT: begin
        next_state = IDLE;
        if (code == CHAR_FF) begin
          next_state  = CLEAR;
          x_nxt       = '0;
          y_nxt       = '0;
          start       = 1'b1;
          start_count = CELLS_A;
        end else begin
          adv   = (code == CHAR_NL) || (cursor_x == LAST_COL);
          x_nxt = (code == CHAR_NL) ? 6'd0 : (cursor_x + 6'd1);
          if (adv) begin
            if (cursor_y != LAST_ROW) begin
              y_nxt = cursor_y + 5'd1;
            end else begin
`ifdef TEXT_SCROLL_EN
              next_state  = SCROLL;
              start       = 1'b1;
              start_copy  = 1'b1;
              start_count = SCROLL_LEN;
`else
              next_state  = CLR_ROW;
              y_nxt       = '0;
              start       = 1'b1;
              start_count = COLS_A;
`endif
            end
          end
        end
      end
      CLR_ROW: begin
        if (fill_done) next_state = IDLE;
      end
`ifdef TEXT_SCROLL_EN
      SCROLL: begin
        if (fill_done) begin
          next_state  = CLR_ROW;
          start       = 1'b1;
          start_base  = LAST_ROW_BASE;
          start_count = COLS_A;
        end
      end
`endif
      default: next_state = CLEAR;
    endcase
  end

  // State, cursor and handshake/status flags.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state      <= CLEAR;
      cursor_x   <= '0;
      cursor_y   <= '0;
      char_ready <= 1'b0;
      busy       <= 1'b1;
    end else begin
      state      <= next_state;
      cursor_x   <= x_nxt;
      cursor_y   <= y_nxt;
      char_ready <= (next_state == IDLE);
      busy       <= (next_state == CLEAR) || (next_state == CLR_ROW) || (next_state == SCROLL);
    end
  end

  // Character latch at the handshake edge only.
  always_ff @(posedge CLOCK_50) begin
    if (char_valid && char_ready) code <= char_data;
  end

  // Write strobe and address: bulk engine or a printable PUT.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      mem_we    <= 1'b0;
      mem_waddr <= '0;
    end else begin
      mem_we <= fill_we || put_we;
      if (fill_we) begin
        mem_waddr <= fill_waddr;
      end else if (put_we) begin
        mem_waddr <= cell_addr(cursor_x, cursor_y);
      end
    end
  end

  // Write data follows the same source selection as the address.
  always_ff @(posedge CLOCK_50) begin
    if (fill_we) begin
      mem_wdata <= fill_wdata;
    end else if (put_we) begin
      mem_wdata <= code;
    end
  end

endmodule
